hilo_unit: RTL and testbench

- Downstream consumer of the 32-bit ALU's High/Low result pair. Holds the architectural HI and LO registers for MIPS mult/div/mfhi/mflo/mthi/mtlo.
- Models multi-cycle mult/div latency. It captures the ALU result when the operation issues and commits it to HI/LO after a programmable number of cycles.
- Asserts stall to the pipeline when an access hits a pending result.

---
 rtl/hilo_unit.sv | 98 +++++++++
 tb/tb_hilo_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register unit with modelled multi-cycle mult/div latency and pipeline stall.
// Optional macro HILO_BYPASS_EN: in the commit cycle, reads return the result about to commit.
module hilo_unit #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_control,
  input  logic [31:0] alu_high,
  input  logic [31:0] alu_low,
  input  logic        start,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t      state, state_nxt;
  logic [31:0] hi, lo, shadow_hi, shadow_lo;
  logic [3:0]  cnt;
  logic        is_mul, is_div, issue, commit, mt_ok;

  assign is_mul = (alu_control == ALU_MUL);
  assign is_div = (alu_control == ALU_DIV);
  assign issue  = (state == IDLE) && start && (is_mul || is_div);
  assign commit = (state == BUSY) && (cnt == 4'd1);
  // Any start in IDLE owns the cycle; a concurrent mt write is dropped.
  assign mt_ok  = (state == IDLE) && !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue)  state_nxt = BUSY;
      BUSY:    if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      cnt       <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
      if (commit) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end
    end else if (issue) begin
      shadow_hi <= alu_high;
      shadow_lo <= alu_low;
      cnt       <= is_mul ? MUL_CNT : DIV_CNT;
    end else if (mt_ok) begin
      if (mthi) hi <= mt_data;
      if (mtlo) lo <= mt_data;
    end
  end

  always_comb begin
    logic [31:0] rhi, rlo;
    busy = (state == BUSY);
    rhi  = hi;
    rlo  = lo;
`ifdef HILO_BYPASS_EN
    if (commit) begin
      rhi = shadow_hi;
      rlo = shadow_lo;
    end
    stall = busy && (start || mthi || mtlo || ((mfhi || mflo) && !commit));
`else
    stall = busy && (start || mthi || mtlo || mfhi || mflo);
`endif
    if (mfhi)      rd_data = rhi;
    else if (mflo) rd_data = rlo;
    else           rd_data = '0;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized + directed bench for hilo_unit against a transaction-level HI/LO model.
module tb_hilo_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_control;
  logic [31:0] alu_high, alu_low, mt_data, rd_data;
  logic        start, mthi, mtlo, mfhi, mflo, busy, stall;

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .alu_control(alu_control),
    .alu_high(alu_high), .alu_low(alu_low), .start(start),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .mfhi(mfhi), .mflo(mflo), .rd_data(rd_data),
    .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model: architectural HI/LO plus one pending result with cycles remaining
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_rem;

  logic [31:0] o_rd;
  logic        o_stall, o_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_rem = 0;
  endtask

  task automatic idle_inputs();
    start = 0; mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
    alu_control = '0; alu_high = '0; alu_low = '0; mt_data = '0;
  endtask

  // Check one cycle's combinational outputs, then advance model and DUT by one edge.
  task automatic tick();
    logic        pend, commit, est;
    logic [31:0] eh, el, erd;
    #1;
    pend   = (m_rem > 0);
    commit = (m_rem == 1);
    eh = m_hi;
    el = m_lo;
`ifdef HILO_BYPASS_EN
    if (commit) begin eh = m_ph; el = m_pl; end
    est = pend && (start || mthi || mtlo || ((mfhi || mflo) && !commit));
`else
    est = pend && (start || mthi || mtlo || mfhi || mflo);
`endif
    erd = mfhi ? eh : (mflo ? el : 32'h0);
    o_rd = rd_data; o_stall = stall; o_busy = busy;
    chk("rd_data", rd_data, erd);
    chk("stall", {31'b0, stall}, {31'b0, est});
    chk("busy", {31'b0, busy}, {31'b0, pend});
    @(posedge clk);
    if (pend) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = m_ph; m_lo = m_pl; end
    end else if (start) begin
      if (alu_control == 4'd3)      begin m_ph = alu_high; m_pl = alu_low; m_rem = MUL_LAT; end
      else if (alu_control == 4'd4) begin m_ph = alu_high; m_pl = alu_low; m_rem = DIV_LAT; end
    end else begin
      if (mthi) m_hi = mt_data;
      if (mtlo) m_lo = mt_data;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] ctl, input logic [31:0] h, input logic [31:0] l);
    start = 1; alu_control = ctl; alu_high = h; alu_low = l;
    tick();
    start = 0;
  endtask

  initial begin
    int nb, ns;
    logic got;
    logic [31:0] first_rd;

    idle_inputs();
    model_reset();
    reset = 1;
    mfhi  = 1;
    #2;
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    reset = 0;
    mfhi  = 0;

    // 1: reads after reset
    mfhi = 1; tick(); chk("t1_mfhi", o_rd, 32'h0);
    mfhi = 0; mflo = 1; tick(); chk("t1_mflo", o_rd, 32'h0);
    mflo = 0;

    // 2: mult latency and operand sampling
    issue(4'd3, 32'h0000_0001, 32'h8000_0000);
    alu_high = 32'hFFFF_FFFF; alu_low = 32'hFFFF_FFFF;
    nb = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (o_busy) nb++; end
    chk("t2_busy_cycles", nb, MUL_LAT);
    mfhi = 1; tick(); chk("t2_hi", o_rd, 32'h0000_0001);
    mfhi = 0; mflo = 1; tick(); chk("t2_lo", o_rd, 32'h8000_0000);
    mflo = 0;

    // 3: div with mflo held
    issue(4'd4, 32'h0000_0007, 32'h0000_0002);
    mflo = 1; ns = 0; got = 0; first_rd = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_stall) ns++;
      else if (!got) begin got = 1; first_rd = o_rd; end
    end
`ifdef HILO_BYPASS_EN
    chk("t3_stall_cycles", ns, DIV_LAT - 1);
`else
    chk("t3_stall_cycles", ns, DIV_LAT);
`endif
    chk("t3_rd_after", first_rd, 32'h0000_0002);
    mflo = 0;

    // 4: mthi/mtlo in IDLE, then mthi while busy
    mthi = 1; mtlo = 1; mt_data = 32'hDEAD_BEEF; tick();
    mthi = 0; mtlo = 0;
    mfhi = 1; tick(); chk("t4_hi", o_rd, 32'hDEAD_BEEF);
    mfhi = 0; mflo = 1; tick(); chk("t4_lo", o_rd, 32'hDEAD_BEEF);
    mflo = 0;
    issue(4'd3, 32'h0000_0055, 32'h0000_0066);
    mthi = 1; mt_data = 32'h1234_5678; tick(); chk("t4_mthi_stall", {31'b0, o_stall}, 32'h1);
    tick();
    mthi = 0; mfhi = 1; tick(); chk("t4_hi_unchanged", o_rd, 32'hDEAD_BEEF);
    mfhi = 0;
    for (int i = 0; i < 3; i++) tick();
    mfhi = 1; tick(); chk("t4_hi_commit", o_rd, 32'h0000_0055);
    mfhi = 0;

    // 5: non-mult/div start ignored; re-issue during BUSY stalled
    issue(4'd2, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    tick(); chk("t5_ignored_busy", {31'b0, o_busy}, 32'h0);
    mfhi = 1; tick(); chk("t5_hi_kept", o_rd, 32'h0000_0055);
    mfhi = 0;
    issue(4'd3, 32'h0000_000A, 32'h0000_000B);
    start = 1; alu_control = 4'd4; alu_high = 32'hC; alu_low = 32'hD;
    tick(); chk("t5_restart_stall", {31'b0, o_stall}, 32'h1);
    start = 0;
    nb = 1;
    for (int i = 0; i < 10; i++) begin tick(); if (o_busy) nb++; end
    chk("t5_busy_cycles", nb, MUL_LAT);
    mfhi = 1; tick(); chk("t5_hi", o_rd, 32'h0000_000A);
    mfhi = 0;

    // 6: reset mid-operation aborts it
    issue(4'd3, 32'h1111_1111, 32'h2222_2222);
    tick(); tick();
    reset = 1;
    #1;
    chk("t6_busy_now", {31'b0, busy}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      mfhi = i[0]; mflo = !i[0]; tick();
    end
    chk("t6_no_commit", o_rd, 32'h0);
    mfhi = 0; mflo = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      alu_high = $urandom; alu_low = $urandom; mt_data = $urandom;
      alu_control = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(3, 4));
      start = ($urandom_range(0, 3) == 0);
      if (!start) begin
        mthi = ($urandom_range(0, 3) == 0);
        mtlo = ($urandom_range(0, 3) == 0);
      end
      mfhi = $urandom_range(0, 1);
      mflo = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
